// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code to ASCII translator: synchronises the receiver's busy flag,
// tracks break/extended prefixes and shift, and buffers characters in a small FIFO.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ps2_data,
  input  logic       ps2_bsy,
  output logic [7:0] ascii,
  output logic       valid,
  input  logic       ready,
  output logic       shift,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BREAK     = 2'd1,
    ST_EXT       = 2'd2,
    ST_EXT_BREAK = 2'd3
  } state_t;

  // Returns {mapped, character}; letters are uppercased when shift is held.
  function automatic logic [8:0] map_code(input logic [7:0] c, input logic sh);
    logic [7:0] ch;
    logic       hit;
    logic       letter;
    ch     = 8'h00;
    hit    = 1'b1;
    letter = 1'b1;
    case (c)
      8'h1C: ch = 8'h61;  8'h32: ch = 8'h62;  8'h21: ch = 8'h63;  8'h23: ch = 8'h64;
      8'h24: ch = 8'h65;  8'h2B: ch = 8'h66;  8'h34: ch = 8'h67;  8'h33: ch = 8'h68;
      8'h43: ch = 8'h69;  8'h3B: ch = 8'h6A;  8'h42: ch = 8'h6B;  8'h4B: ch = 8'h6C;
      8'h3A: ch = 8'h6D;  8'h31: ch = 8'h6E;  8'h44: ch = 8'h6F;  8'h4D: ch = 8'h70;
      8'h15: ch = 8'h71;  8'h2D: ch = 8'h72;  8'h1B: ch = 8'h73;  8'h2C: ch = 8'h74;
      8'h3C: ch = 8'h75;  8'h2A: ch = 8'h76;  8'h1D: ch = 8'h77;  8'h22: ch = 8'h78;
      8'h35: ch = 8'h79;  8'h1A: ch = 8'h7A;
      8'h45: begin ch = 8'h30; letter = 1'b0; end
      8'h16: begin ch = 8'h31; letter = 1'b0; end
      8'h1E: begin ch = 8'h32; letter = 1'b0; end
      8'h26: begin ch = 8'h33; letter = 1'b0; end
      8'h25: begin ch = 8'h34; letter = 1'b0; end
      8'h2E: begin ch = 8'h35; letter = 1'b0; end
      8'h36: begin ch = 8'h36; letter = 1'b0; end
      8'h3D: begin ch = 8'h37; letter = 1'b0; end
      8'h3E: begin ch = 8'h38; letter = 1'b0; end
      8'h46: begin ch = 8'h39; letter = 1'b0; end
      8'h29: begin ch = 8'h20; letter = 1'b0; end
      8'h5A: begin ch = 8'h0D; letter = 1'b0; end
      8'h66: begin ch = 8'h08; letter = 1'b0; end
      default: begin hit = 1'b0; letter = 1'b0; end
    endcase
    if (letter && sh) begin
      ch = ch - 8'h20;
    end else begin
      ch = ch;
    end
    return {hit, ch};
  endfunction

  logic [SYNC_STAGES-1:0] bsy_sync_q;
  logic                   bsy_prev_q;
  logic                   fall_q;
  logic [7:0]             code_q;
  logic                   code_vld_q;
  logic                   bsy_s;

  state_t state_q, state_d;
  logic   shift_q, shift_d;
  logic   push_s;
  logic   is_shift_s;
  logic [8:0] map_s;

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        overflow_q;
  logic        empty_s, full_s, pop_s, wr_en_s, drop_s;

  assign bsy_s = bsy_sync_q[SYNC_STAGES-1];

  // Synchroniser and falling-edge detect; flops reset high so release is edge-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      bsy_sync_q <= '1;
      bsy_prev_q <= 1'b1;
      fall_q     <= 1'b0;
      code_vld_q <= 1'b0;
      code_q     <= 8'h00;
    end else begin
      bsy_sync_q <= {bsy_sync_q[SYNC_STAGES-2:0], ps2_bsy};
      bsy_prev_q <= bsy_s;
      fall_q     <= bsy_prev_q & ~bsy_s;
      code_vld_q <= fall_q;
      if (fall_q) begin
        code_q <= ps2_data;
      end
    end
  end

  // Prefix FSM and shift state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
    end
  end

  assign is_shift_s = (code_q == 8'h12) || (code_q == 8'h59);
  assign map_s      = map_code(code_q, shift_q);

  // Next-state decode; characters use the shift value held before this byte.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    push_s  = 1'b0;
    if (code_vld_q) begin
      case (state_q)
        ST_IDLE: begin
          if (code_q == 8'hF0) begin
            state_d = ST_BREAK;
          end else if (code_q == 8'hE0) begin
            state_d = ST_EXT;
          end else if (is_shift_s) begin
            shift_d = 1'b1;
          end else begin
            push_s = map_s[8];
          end
        end
        ST_BREAK: begin
          if (is_shift_s) begin
            shift_d = 1'b0;
          end else begin
            shift_d = shift_q;
          end
          state_d = ST_IDLE;
        end
        ST_EXT: begin
          if (code_q == 8'hF0) begin
            state_d = ST_EXT_BREAK;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_EXT_BREAK: state_d = ST_IDLE;
        default:      state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_s   = ~empty_s & ready;
  // When full, a same-cycle pop frees the slot being written.
  assign wr_en_s = push_s & (~full_s | pop_s);
  assign drop_s  = push_s & full_s & ~pop_s;

  // FIFO pointers and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (drop_s) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= map_s[7:0];
    end
  end

  assign ascii    = empty_s ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign valid    = ~empty_s;
  assign shift    = shift_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed self-checking bench for ps2_scancode_decoder (FIFO_DEPTH=4, SYNC_STAGES=2).
module tb_ps2_scancode_decoder;

  logic       clk;
  logic       rst;
  logic [7:0] ps2_data;
  logic       ps2_bsy;
  logic [7:0] ascii;
  logic       valid;
  logic       ready;
  logic       shift;
  logic       overflow;

  int total;
  int bad;

  ps2_scancode_decoder #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_data (ps2_data),
    .ps2_bsy  (ps2_bsy),
    .ascii    (ascii),
    .valid    (valid),
    .ready    (ready),
    .shift    (shift),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame: bsy low for 6 cycles; push lands on the 5th edge after the fall.
  task automatic send_gen(input logic [7:0] c, input bit pop_at_push);
    ps2_data = c;
    ps2_bsy  = 1'b0;
    step(4);
    if (pop_at_push) ready = 1'b1;
    step(1);
    ready = 1'b0;
    step(1);
    ps2_bsy = 1'b1;
    step(4);
  endtask

  task automatic send(input logic [7:0] c);
    send_gen(c, 1'b0);
  endtask

  task automatic pop_one();
    ready = 1'b1;
    step(1);
    ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(1);
  endtask

  initial begin
    logic [7:0] exp_q [$];
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    ps2_bsy  = 1'b1;
    ps2_data = 8'h00;
    ready    = 1'b0;

    // Reset values
    step(3);
    check("rst_ascii", {24'd0, ascii}, 32'h00);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_shift", {31'd0, shift}, 32'd0);
    check("rst_ovf",   {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    step(5);
    check("rel_valid", {31'd0, valid}, 32'd0);

    // Single key with latency: valid rises exactly 5 edges after the pin fall
    ready    = 1'b1;
    ps2_data = 8'h15;
    ps2_bsy  = 1'b0;
    step(4);
    check("lat_early", {31'd0, valid}, 32'd0);
    step(1);
    check("lat_valid", {31'd0, valid}, 32'd1);
    check("lat_ascii", {24'd0, ascii}, 32'h71);
    step(1);
    check("lat_pulse", {31'd0, valid}, 32'd0);
    ps2_bsy = 1'b1;
    step(4);
    check("lat_rise", {31'd0, valid}, 32'd0);
    ready = 1'b0;

    // Shift sequence, including uppercase Z at the top of the letter range
    send(8'h12);
    check("sh_on", {31'd0, shift}, 32'd1);
    send(8'h15);
    check("sh_q_valid", {31'd0, valid}, 32'd1);
    check("sh_q_ascii", {24'd0, ascii}, 32'h51);
    send(8'h1A);
    send(8'hF0);
    check("sh_brk_hold", {31'd0, shift}, 32'd1);
    send(8'h12);
    check("sh_off", {31'd0, shift}, 32'd0);
    send(8'h15);
    exp_q = '{8'h51, 8'h5A, 8'h71};
    foreach (exp_q[i]) begin
      check($sformatf("sh_pop%0d", i), {24'd0, ascii}, {24'd0, exp_q[i]});
      pop_one();
    end
    check("sh_empty", {31'd0, valid}, 32'd0);

    // Right shift, digits ignore shift, special keys, unmapped code dropped
    send(8'h59);
    check("rsh_on", {31'd0, shift}, 32'd1);
    send(8'h16);
    send(8'h29);
    send(8'h0E);
    send(8'h5A);
    send(8'h66);
    send(8'hF0);
    send(8'h59);
    check("rsh_off", {31'd0, shift}, 32'd0);
    check("misc_ovf", {31'd0, overflow}, 32'd0);
    exp_q = '{8'h31, 8'h20, 8'h0D, 8'h08};
    foreach (exp_q[i]) begin
      check($sformatf("misc_pop%0d", i), {24'd0, ascii}, {24'd0, exp_q[i]});
      pop_one();
    end
    check("misc_empty", {31'd0, valid}, 32'd0);

    // Break and extended sequences push nothing
    send(8'hF0); send(8'h15);
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("bx_none", {31'd0, valid}, 32'd0);
    send(8'h1C);
    check("bx_valid", {31'd0, valid}, 32'd1);
    check("bx_ascii", {24'd0, ascii}, 32'h61);
    pop_one();

    // Overflow: fifth character dropped, sticky flag
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
    check("ovf_before", {31'd0, overflow}, 32'd0);
    send(8'h2E);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34};
    foreach (exp_q[i]) begin
      check($sformatf("ovf_pop%0d", i), {24'd0, ascii}, {24'd0, exp_q[i]});
      pop_one();
    end
    check("ovf_empty", {31'd0, valid}, 32'd0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Full FIFO with a pop on the push cycle: nothing dropped
    do_reset();
    check("rst2_ovf", {31'd0, overflow}, 32'd0);
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
    send_gen(8'h36, 1'b1);
    check("fp_ovf", {31'd0, overflow}, 32'd0);
    exp_q = '{8'h32, 8'h33, 8'h34, 8'h36};
    foreach (exp_q[i]) begin
      check($sformatf("fp_pop%0d", i), {24'd0, ascii}, {24'd0, exp_q[i]});
      pop_one();
    end
    check("fp_empty", {31'd0, valid}, 32'd0);

    // Reset after shift and a pending break discards both
    send(8'h12);
    send(8'hF0);
    do_reset();
    check("rm_shift", {31'd0, shift}, 32'd0);
    send(8'h15);
    check("rm_valid", {31'd0, valid}, 32'd1);
    check("rm_ascii", {24'd0, ascii}, 32'h71);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
